// File: rtl/shift_seq_pkg.sv
// Shared definitions for the multi-cycle word shifter: direction codes,
// sequencer state encoding and the default lane count.
package shift_seq_pkg;

    localparam int   WORD_BYTES_DEF = 4;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAIN  = 2'd1,
        SPILL = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/SHIFTER_8Bit.sv
// 8-bit logical shifter: S[3] selects right (1) or left (0), S[2:0] is the amount.
module SHIFTER_8Bit (
    input  logic [7:0] A,
    input  logic [3:0] S,
    output logic [7:0] out
);

    assign out = S[3] ? (A >> S[2:0]) : (A << S[2:0]);

endmodule

// File: rtl/shift_sequencer.sv
// Word shifter built from one shared 8-bit shifter: each byte lane takes a MAIN
// cycle (own byte) and a SPILL cycle (bits carried in from the neighbouring byte).
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WORD_BYTES = WORD_BYTES_DEF,
    parameter int AMT_W      = $clog2(8 * WORD_BYTES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*WORD_BYTES-1:0] in_data,
    input  logic [AMT_W-1:0]        in_amt,
    input  logic                    in_dir,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*WORD_BYTES-1:0] out_data,
    output logic                    busy
);

    localparam int W      = 8 * WORD_BYTES;
    localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

    seq_state_e        state_q;
    logic              dir_q;
    logic [2:0]        r_q;
    logic [LANE_W-1:0] lane_q;
    logic [W-1:0]      wb_q;
    logic [W-1:0]      acc_q;
    logic [W-1:0]      acc_d;
    logic              out_valid_q;
    logic [W-1:0]      out_data_q;

    logic [W-1:0]      wb_d;
    logic [AMT_W-1:0]  byte_shift;
    logic [7:0]        wb_byte [WORD_BYTES];
    logic [7:0]        nb_byte;
    logic              nb_exists;
    logic [LANE_W-1:0] nb_idx;
    logic [7:0]        sh_a;
    logic [3:0]        sh_s;
    logic [7:0]        sh_out;
    logic              lane_or;

    // Whole-byte part of the shift is applied once at capture time.
    assign byte_shift = {in_amt[AMT_W-1:3], 3'b000};
    assign wb_d       = (in_dir == DIR_RIGHT) ? (in_data >> byte_shift) : (in_data << byte_shift);

    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            assign wb_byte[gi] = wb_q[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        nb_exists = 1'b0;
        nb_idx    = lane_q;
        if (dir_q == DIR_LEFT) begin
            if (lane_q != '0) begin
                nb_exists = 1'b1;
                nb_idx    = lane_q - 1'b1;
            end
        end else begin
            if (lane_q != LAST_LANE) begin
                nb_exists = 1'b1;
                nb_idx    = lane_q + 1'b1;
            end
        end
        nb_byte = nb_exists ? wb_byte[nb_idx] : 8'd0;

        if (state_q == SPILL) begin
            sh_a    = nb_byte;
            sh_s    = {~dir_q, 3'd0 - r_q};
            // r=0 wraps the complementary amount to 0 and would copy the whole neighbour.
            lane_or = nb_exists && (r_q != 3'd0);
        end else begin
            sh_a    = wb_byte[lane_q];
            sh_s    = {dir_q, r_q};
            lane_or = (state_q == MAIN);
        end

        acc_d = acc_q;
        if (lane_or) begin
            acc_d[{lane_q, 3'b000} +: 8] = acc_q[{lane_q, 3'b000} +: 8] | sh_out;
        end
    end

    SHIFTER_8Bit u_shifter (
        .A   (sh_a),
        .S   (sh_s),
        .out (sh_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dir_q       <= DIR_LEFT;
            r_q         <= 3'd0;
            lane_q      <= '0;
            wb_q        <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dir_q   <= in_dir;
                        r_q     <= in_amt[2:0];
                        wb_q    <= wb_d;
                        acc_q   <= '0;
                        lane_q  <= '0;
                        state_q <= MAIN;
                    end
                end
                MAIN: begin
                    acc_q   <= acc_d;
                    state_q <= SPILL;
                end
                SPILL: begin
                    acc_q <= acc_d;
                    if (lane_q == LAST_LANE) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= acc_d;
                        state_q     <= DONE;
                    end else begin
                        lane_q  <= lane_q + 1'b1;
                        state_q <= MAIN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a transaction-level reference model
// checked against the DUT on every falling clock edge.
module tb_shift_sequencer;

    localparam int WB = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic        in_dir;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    // Reference model state: idle/busy, edges remaining, result.
    bit          m_busy  = 0;
    bit          m_valid = 0;
    int          m_left  = 0;
    logic [31:0] m_res   = 0;
    logic [31:0] m_data  = 0;

    shift_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 0;
            m_valid = 0;
            m_left  = 0;
            m_data  = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1;
                m_left = 2 * WB;
                m_res  = in_dir ? (in_data >> in_amt) : (in_data << in_amt);
            end
        end else if (!m_valid) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1;
                m_data  = m_res;
            end
        end else if (out_ready) begin
            m_valid = 0;
            m_busy  = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc in_ready",  32'(in_ready),  32'(!m_busy));
            check("cyc busy",      32'(busy),      32'(m_busy));
            check("cyc out_valid", 32'(out_valid), 32'(m_valid));
            check("cyc out_data",  out_data,       m_data);
        end
    end

    task automatic issue(input logic [31:0] d, input logic [4:0] a, input logic dr, input string tag);
        @(posedge clk); #1;
        in_data  = d;
        in_amt   = a;
        in_dir   = dr;
        in_valid = 1'b1;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_amt   = 5'($urandom);
        in_dir   = ~dr;
    endtask

    task automatic wait_result(input logic [31:0] exp, input string tag);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(2 * WB));
        check({tag, " out_data"}, out_data, exp);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_op(input logic [31:0] d, input logic [4:0] a, input logic dr,
                          input logic [31:0] exp, input string tag);
        issue(d, a, dr, tag);
        wait_result(exp, tag);
        $display("op %s: data=%h amt=%0d dir=%0d -> %h (exp %h)", tag, d, a, dr, out_data, exp);
        release_result(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [4:0]  ra;
        logic        rdir;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_dir    = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst in_ready",  32'(in_ready),  32'd1);
        check("rst busy",      32'(busy),      32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data",  out_data,       32'h0);
        rst_n  = 1'b1;
        chk_en = 1;

        run_op(32'h12345678, 5'd0,  1'b0, 32'h12345678, "L0");
        run_op(32'h12345678, 5'd4,  1'b0, 32'h23456780, "L4");
        run_op(32'h12345678, 5'd12, 1'b1, 32'h00012345, "R12");
        run_op(32'hFFFFFFFF, 5'd31, 1'b0, 32'h80000000, "L31");
        run_op(32'hFFFFFFFF, 5'd31, 1'b1, 32'h00000001, "R31");
        run_op(32'hA5A5A5A5, 5'd8,  1'b1, 32'h00A5A5A5, "R8");
        run_op(32'h80000001, 5'd9,  1'b0, 32'h00000200, "L9");
        run_op(32'h80000001, 5'd17, 1'b1, 32'h00004000, "R17");

        for (int k = 0; k < 6; k++) begin
            rd   = $urandom;
            ra   = 5'($urandom);
            rdir = 1'($urandom);
            run_op(rd, ra, rdir, rdir ? (rd >> ra) : (rd << ra), "RND");
        end

        // Back-pressure: result held while out_ready is low, new request waits.
        issue(32'h12345678, 5'd4, 1'b0, "HOLD");
        wait_result(32'h23456780, "HOLD");
        in_data  = 32'h0000FFFF;
        in_amt   = 5'd16;
        in_dir   = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("HOLD out_valid", 32'(out_valid), 32'd1);
            check("HOLD out_data",  out_data,       32'h23456780);
            check("HOLD in_ready",  32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("HOLD release out_valid", 32'(out_valid), 32'd0);
        check("HOLD release busy",      32'(busy),      32'd0);
        check("HOLD kept out_data",     out_data,       32'h23456780);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("HOLD next accepted", 32'(busy), 32'd1);
        wait_result(32'hFFFF0000, "HOLD2");
        $display("op HOLD2: data=0000ffff amt=16 dir=0 -> %h (exp ffff0000)", out_data);
        release_result("HOLD2");

        // Reset in the middle of an operation.
        issue(32'hDEADBEEF, 5'd5, 1'b1, "RST");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("RST out_valid", 32'(out_valid), 32'd0);
        check("RST busy",      32'(busy),      32'd0);
        check("RST in_ready",  32'(in_ready),  32'd1);
        check("RST out_data",  out_data,       32'h0);
        #1;
        rst_n = 1'b1;
        $display("op RST: reset asserted mid-operation");
        run_op(32'h00000001, 5'd1, 1'b0, 32'h00000002, "POSTRST");

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
